// File: rtl/evolved_circuit_tester_if.sv
// Host/CUT bundle for the evolved-circuit tester.
// slave: tester side; master: host plus CUT side.
interface evolved_circuit_tester_if #(
    parameter int IN_WIDTH    = 2,
    parameter int NUM_VECTORS = 4
);
    localparam int CW = $clog2(NUM_VECTORS + 1);

    logic                            start;
    logic [NUM_VECTORS*IN_WIDTH-1:0] stim_table;
    logic [NUM_VECTORS-1:0]          exp_table;
    logic [IN_WIDTH-1:0]             cut_in;
    logic                            cut_out;
    logic                            busy;
    logic                            done;
    logic [NUM_VECTORS-1:0]          fail_mask;
    logic [CW-1:0]                   mismatch_count;
    logic [CW-1:0]                   unstable_count;

    modport slave (
        input  start, stim_table, exp_table, cut_out,
        output cut_in, busy, done, fail_mask,
        output mismatch_count, unstable_count
    );

    modport master (
        output start, stim_table, exp_table, cut_out,
        input  cut_in, busy, done, fail_mask,
        input  mismatch_count, unstable_count
    );
endinterface

// File: rtl/evolved_circuit_tester.sv
// Drives a captured vector table into an async CUT, samples its
// synchronized output and reports per-vector pass/fail and counts.
// Ports: clk, rst (sync, active high), bus (slave modport).
module evolved_circuit_tester #(
    parameter int IN_WIDTH      = 2,
    parameter int NUM_VECTORS   = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input logic                      clk,
    input logic                      rst,
    evolved_circuit_tester_if.slave  bus
);
    localparam int CW  = $clog2(NUM_VECTORS + 1);
    localparam int VW  = $clog2(NUM_VECTORS + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int SPW = $clog2(SAMPLES + 1);
    localparam int TW  = NUM_VECTORS * IN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [SCW-1:0]         set_cnt_q, set_cnt_d;
    logic [SPW-1:0]         samp_cnt_q, samp_cnt_d;
    logic [VW-1:0]          vidx_q, vidx_d;
    logic [TW-1:0]          stim_q, stim_d;
    logic [NUM_VECTORS-1:0] exp_q, exp_d;
    logic [IN_WIDTH-1:0]    cut_in_q, cut_in_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_VECTORS-1:0] fail_q, fail_d;
    logic [CW-1:0]          mm_q, mm_d;
    logic [CW-1:0]          un_q, un_d;
    logic                   first_q, first_d;
    logic                   diff_q, diff_d;
    logic                   sync1_q, sync2_q;

    logic                   first_now;
    logic                   diff_now;
    logic                   exp_bit;
    logic [IN_WIDTH-1:0]    next_vec;
    logic [NUM_VECTORS-1:0] vbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            set_cnt_q  <= '0;
            samp_cnt_q <= '0;
            vidx_q     <= '0;
            stim_q     <= '0;
            exp_q      <= '0;
            cut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= '0;
            mm_q       <= '0;
            un_q       <= '0;
            first_q    <= 1'b0;
            diff_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            vidx_q     <= vidx_d;
            stim_q     <= stim_d;
            exp_q      <= exp_d;
            cut_in_q   <= cut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            mm_q       <= mm_d;
            un_q       <= un_d;
            first_q    <= first_d;
            diff_q     <= diff_d;
            sync1_q    <= bus.cut_out;
            sync2_q    <= sync1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        samp_cnt_d = samp_cnt_q;
        vidx_d     = vidx_q;
        stim_d     = stim_q;
        exp_d      = exp_q;
        cut_in_d   = cut_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fail_d     = fail_q;
        mm_d       = mm_q;
        un_d       = un_q;
        first_d    = first_q;
        diff_d     = diff_q;

        exp_bit  = 1'b0;
        next_vec = '0;
        vbit     = '0;
        for (int v = 0; v < NUM_VECTORS; v++) begin
            if (v == int'(vidx_q)) begin
                exp_bit = exp_q[v];
                vbit[v] = 1'b1;
            end
            if (v == int'(vidx_q) + 1)
                next_vec = stim_q[v*IN_WIDTH +: IN_WIDTH];
        end

        // First sample of a vector is the reference; later ones
        // only record whether they disagreed with it.
        first_now = (samp_cnt_q == '0) ? sync2_q : first_q;
        diff_now  = diff_q |
                    ((samp_cnt_q != '0) && (sync2_q != first_q));

        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (state_q == S_FINISH)
                    state_d = S_IDLE;
                if (bus.start) begin
                    stim_d    = bus.stim_table;
                    exp_d     = bus.exp_table;
                    cut_in_d  = bus.stim_table[IN_WIDTH-1:0];
                    busy_d    = 1'b1;
                    fail_d    = '0;
                    mm_d      = '0;
                    un_d      = '0;
                    vidx_d    = '0;
                    set_cnt_d = '0;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (set_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
                    set_cnt_d  = '0;
                    samp_cnt_d = '0;
                    diff_d     = 1'b0;
                    state_d    = S_SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + SCW'(1);
                end
            end
            S_SAMPLE: begin
                first_d = first_now;
                diff_d  = diff_now;
                if (samp_cnt_q == SPW'(SAMPLES - 1)) begin
                    samp_cnt_d = '0;
                    diff_d     = 1'b0;
                    if (diff_now) begin
                        un_d   = un_q + CW'(1);
                        fail_d = fail_q | vbit;
                    end else if (first_now != exp_bit) begin
                        mm_d   = mm_q + CW'(1);
                        fail_d = fail_q | vbit;
                    end
                    if (vidx_q == VW'(NUM_VECTORS - 1)) begin
                        cut_in_d = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_FINISH;
                    end else begin
                        vidx_d   = vidx_q + VW'(1);
                        cut_in_d = next_vec;
                        state_d  = S_SETTLE;
                    end
                end else begin
                    samp_cnt_d = samp_cnt_q + SPW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cut_in         = cut_in_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.fail_mask      = fail_q;
    assign bus.mismatch_count = mm_q;
    assign bus.unstable_count = un_q;
endmodule

// File: tb/tb_evolved_circuit_tester.sv
// Directed bench for evolved_circuit_tester with a result scoreboard.
// CUT model: out = in[0] & ~in[1], optionally oscillating on input 1.
module tb_evolved_circuit_tester;
    typedef struct {
        logic [3:0] fm;
        logic [2:0] mm;
        logic [2:0] un;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic tog = 1'b0;
    logic tog_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    evolved_circuit_tester_if #(.IN_WIDTH(2), .NUM_VECTORS(4)) bus();

    evolved_circuit_tester #(
        .IN_WIDTH(2), .NUM_VECTORS(4),
        .SETTLE_CYCLES(4), .SAMPLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    assign bus.cut_out = (tog_en && bus.cut_in == 2'd1) ? tog :
                         (bus.cut_in[0] & ~bus.cut_in[1]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [7:0] stim,
                                   input logic [3:0] expt,
                                   input bit tm);
        res_t r;
        logic [1:0] in;
        logic o;
        r.fm = '0;
        r.mm = '0;
        r.un = '0;
        for (int k = 0; k < 4; k++) begin
            in = 2'((stim >> (2 * k)) & 8'h3);
            if (tm && in == 2'd1) begin
                r.un++;
                r.fm[k] = 1'b1;
            end else begin
                o = in[0] & ~in[1];
                if (o != expt[k]) begin
                    r.mm++;
                    r.fm[k] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic run(input logic [7:0] stim, input logic [3:0] expt,
                       input bit tm, input bit pulses, input bit chg,
                       input bit chain);
        res_t r;
        tog_en = tm;
        bus.stim_table = stim;
        bus.exp_table = expt;
        bus.start = 1'b1;
        sb.push_back(model(stim, expt, tm));
        tick();
        bus.start = 1'b0;
        chk("e0_cut_in", 32'(bus.cut_in), 32'(stim[1:0]));
        chk("e0_busy", 32'(bus.busy), 1);
        chk("e0_done", 32'(bus.done), 0);
        chk("e0_fail", 32'(bus.fail_mask), 0);
        chk("e0_mm", 32'(bus.mismatch_count), 0);
        chk("e0_un", 32'(bus.unstable_count), 0);
        for (int e = 1; e <= 28; e++) begin
            if (pulses && (e == 3 || e == 15)) bus.start = 1'b1;
            if (chg && e == 5) bus.stim_table = 8'hFF;
            tick();
            bus.start = 1'b0;
            chk("done_edge", 32'(bus.done), (e == 28) ? 1 : 0);
            if (e % 7 == 0 && e < 28)
                chk("cut_in_step", 32'(bus.cut_in),
                    32'((stim >> (2 * (e / 7))) & 8'h3));
            if (e < 28) chk("busy_run", 32'(bus.busy), 1);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    r = sb.pop_front();
                    chk("fail_mask", 32'(bus.fail_mask), 32'(r.fm));
                    chk("mm_count", 32'(bus.mismatch_count), 32'(r.mm));
                    chk("un_count", 32'(bus.unstable_count), 32'(r.un));
                    chk("fin_cut_in", 32'(bus.cut_in), 0);
                    chk("fin_busy", 32'(bus.busy), 0);
                end
            end
        end
        if (chain) begin
            bus.start = 1'b1;
        end else begin
            tick();
            chk("done_once", 32'(bus.done), 0);
            chk("hold_fail", 32'(bus.fail_mask), 32'(model(stim, expt, tm).fm));
        end
        tog_en = 1'b0;
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stim_table = '0;
        bus.exp_table = '0;
        repeat (3) tick();
        chk("rst_cut_in", 32'(bus.cut_in), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fail", 32'(bus.fail_mask), 0);
        chk("rst_mm", 32'(bus.mismatch_count), 0);
        chk("rst_un", 32'(bus.unstable_count), 0);
        rst = 1'b0;
        tick();

        run(8'hE4, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        run(8'hE4, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        run(8'hE4, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        run(8'hE4, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
        run(8'h1B, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);

        bus.stim_table = 8'hE4;
        bus.exp_table = 4'b0110;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cut_in", 32'(bus.cut_in), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_mm", 32'(bus.mismatch_count), 0);
        chk("mid_rst_un", 32'(bus.unstable_count), 0);
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) dn++;
        end
        chk("no_done_after_rst", 32'(dn), 0);

        run(8'hE4, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        run(8'hE4, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/evolved_circuit_tester.md
Name: evolved_circuit_tester

Overview:
- Sequencing controller for one evolved LCELL/NOR circuit under test (CUT).
- On start, drives a stored table of input vectors into the CUT one vector at a time and waits a settle interval after each.
- Samples the CUT output several times per vector, then reports per-vector pass/fail, a stable-mismatch count and an unstable (oscillating) count.
- Sits between the evolution host interface and the asynchronous CUT; the CUT itself is combinational/feedback logic with no clock.

Parameters:
- IN_WIDTH, 2, width of the CUT input bus.
- NUM_VECTORS, 4, number of test vectors per run (>=1).
- SETTLE_CYCLES, 4, clock cycles between applying a vector and the first sample (>=1).
- SAMPLES, 3, consecutive samples taken per vector (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; accepted only when busy=0.
- stim_table  input  NUM_VECTORS*IN_WIDTH  vector v occupies bits [v*IN_WIDTH +: IN_WIDTH]; captured at start.
- exp_table  input  NUM_VECTORS  expected CUT output for vector v in bit v; captured at start.
- cut_in  output  IN_WIDTH  registered drive to the CUT inputs.
- cut_out  input  1  raw asynchronous CUT output.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when results are valid.
- fail_mask  output  NUM_VECTORS  bit v set if vector v failed (mismatch or unstable).
- mismatch_count  output  $clog2(NUM_VECTORS+1)  vectors whose samples were all equal but differed from expected.
- unstable_count  output  $clog2(NUM_VECTORS+1)  vectors whose samples were not all equal.

Behaviour:
- Reset: cut_in=0, busy=0, done=0, fail_mask=0, both counts=0, FSM=IDLE, synchronizer flops=0, captured tables=0.
- cut_out passes through a 2-flop synchronizer; all samples read the synchronizer output.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE with start=1 (edge 0):
  - capture both tables;
  - set cut_in=vector 0, busy=1;
  - clear fail_mask and both counts;
  - go to SETTLE.
- SETTLE: counts SETTLE_CYCLES edges, then goes to SAMPLE.
- SAMPLE: registers the synchronized output on SAMPLES consecutive edges.
  - Vector v is applied at edge v*(SETTLE_CYCLES+SAMPLES).
  - Its samples are taken at edges v*P+SETTLE_CYCLES+1 through v*P+SETTLE_CYCLES+SAMPLES, where P=SETTLE_CYCLES+SAMPLES.
- Evaluation happens at the last-sample edge of each vector:
  - samples not all equal: unstable_count+=1, fail_mask[v]=1;
  - all equal but != exp bit: mismatch_count+=1, fail_mask[v]=1;
  - otherwise pass.
  - At the same edge, cut_in takes vector v+1 and the FSM returns to SETTLE, unless v is the last vector.
- Last vector: its evaluation edge (edge NUM_VECTORS*P) also moves the FSM to FINISH, sets cut_in=0 and busy=0, and sets done=1 for exactly one cycle. FINISH returns to IDLE on the next edge.
- Results hold until the next accepted start.
- start while busy=1 is ignored and not queued.
- start=1 during the done cycle (busy=0) is accepted: new run begins and done still deasserts on the following edge.
- Tables are captured at start; changing stim_table/exp_table mid-run has no effect.
- Counts cannot exceed NUM_VECTORS; no wrap.
- rst mid-run: abort immediately to reset values, no done pulse.
- SAMPLES=1: unstable_count is always 0.

Test Plan:
1. Defaults; CUT modelled as cut_out = in[0]&~in[1]; stim {0,1,2,3}; exp 4'b0010; start at edge 0 -> cut_in steps 0,1,2,3 at edges 0,7,14,21; done at edge 28; fail_mask=0, counts 0/0; cut_in=0 after edge 28.
2. Same as 1 with exp 4'b0110 -> fail_mask=4'b0100, mismatch_count=1, unstable_count=0.
3. Model toggles cut_out every cycle while cut_in==1 -> fail_mask=4'b0010, unstable_count=1, mismatch_count=0.
4. start pulsed at edges 3 and 15 during run -> ignored, single done at edge 28. A start held during the done cycle -> second run begins with cut_in=vector 0, and the counts clear on that edge.
5. rst asserted at edge 10 -> next cycle cut_in=0, busy=0, counts 0, no done. A fresh start then produces results identical to scenario 1.
6. stim_table changed to all 3s at edge 5 -> cut_in sequence and results identical to scenario 1.
